// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: valid/ready data-memory port plus a registered writeback bundle.
// Build option: define MISALIGN_CHECK_EN to trap misaligned half/word accesses (adds misalign_out).
//
// state    | meaning
// IDLE     | take a new op; non-memory ops, ready stores and trapped accesses complete here
// REQ      | request presented, waiting for dmem_req_ready
// WAIT_RSP | load accepted, waiting for dmem_rsp_valid or response timeout
module mem_access_unit #(
   parameter int RSP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] write_data_in,
   input  logic [4:0]  rd_address_in,
   input  logic        data_write_en_in,
   input  logic        reg_write_in,
   input  logic [1:0]  alu_or_load_or_pc_plus_four_in,
   input  logic [31:0] pc_plus_four_in,
   input  logic [1:0]  data_mem_write_command_in,
   input  logic [2:0]  load_gen_command_in,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic [31:0] dmem_addr,
   output logic        dmem_we,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
`ifdef MISALIGN_CHECK_EN
   output logic        misalign_out,
`endif
   output logic        bus_error
);

   localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LOAD = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_tmo_cnt;
   logic          w_is_store, w_mem_op, w_sz_byte, w_sz_half, w_misalign;
   logic          w_complete, w_wb_reg_write, w_timeout;
   logic [31:0]   w_wb_data, w_load_data, w_nonmem_data;
   logic [7:0]    w_rbyte;
   logic [15:0]   w_rhalf;

   assign w_is_store = data_write_en_in;
   assign w_mem_op   = data_write_en_in | (alu_or_load_or_pc_plus_four_in == 2'b01);
   assign w_sz_byte  = w_is_store ? (data_mem_write_command_in == 2'b00)
                                  : (load_gen_command_in[1:0] == 2'b00);
   assign w_sz_half  = w_is_store ? (data_mem_write_command_in == 2'b01)
                                  : (load_gen_command_in[1:0] == 2'b01);

`ifdef MISALIGN_CHECK_EN
   assign w_misalign = w_mem_op & ((w_sz_half & alu_result_in[0]) |
                       (~w_sz_byte & ~w_sz_half & (alu_result_in[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign dmem_addr     = {alu_result_in[31:2], 2'b00};
   assign dmem_we       = w_is_store;
   assign w_nonmem_data = (alu_or_load_or_pc_plus_four_in == 2'b10) ? pc_plus_four_in : alu_result_in;

   always_comb begin
      dmem_wstrb = 4'b1111;
      dmem_wdata = write_data_in;
      if (w_sz_byte) begin
         dmem_wstrb = 4'b0001 << alu_result_in[1:0];
         dmem_wdata = {4{write_data_in[7:0]}};
      end else if (w_sz_half) begin
         dmem_wstrb = alu_result_in[1] ? 4'b1100 : 4'b0011;
         dmem_wdata = {2{write_data_in[15:0]}};
      end
      if (!w_is_store) dmem_wstrb = 4'b0000;
   end

   assign w_rbyte = dmem_rdata[{alu_result_in[1:0], 3'b000} +: 8];
   assign w_rhalf = alu_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   // load_gen_command_in[2] selects zero-extension (LBU/LHU)
   always_comb begin
      w_load_data = dmem_rdata;
      if (w_sz_byte)
         w_load_data = {{24{w_rbyte[7] & ~load_gen_command_in[2]}}, w_rbyte};
      else if (w_sz_half)
         w_load_data = {{16{w_rhalf[15] & ~load_gen_command_in[2]}}, w_rhalf};
   end

   always_comb begin
      w_state_nxt    = r_state;
      dmem_req_valid = 1'b0;
      stall_out      = 1'b0;
      w_complete     = 1'b0;
      w_wb_reg_write = reg_write_in;
      w_wb_data      = w_nonmem_data;
      w_timeout      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_mem_op) begin
               w_complete = 1'b1;
            end else if (w_misalign) begin
               w_complete     = 1'b1;
               w_wb_reg_write = 1'b0;
            end else begin
               dmem_req_valid = 1'b1;
               if (dmem_req_ready && w_is_store) begin
                  w_complete     = 1'b1;
                  w_wb_reg_write = 1'b0;
               end else begin
                  stall_out   = 1'b1;
                  w_state_nxt = dmem_req_ready ? WAIT_RSP : REQ;
               end
            end
         end
         REQ: begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready && w_is_store) begin
               w_complete     = 1'b1;
               w_wb_reg_write = 1'b0;
               w_state_nxt    = IDLE;
            end else begin
               stall_out = 1'b1;
               if (dmem_req_ready) w_state_nxt = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (dmem_rsp_valid) begin
               w_complete  = 1'b1;
               w_wb_data   = w_load_data;
               w_state_nxt = IDLE;
            end else if (RSP_TIMEOUT > 0 && r_tmo_cnt == '0) begin
               w_complete  = 1'b1;
               w_wb_data   = 32'h0;
               w_timeout   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               stall_out = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (reset) begin
         dmem_req_valid = 1'b0;
         stall_out      = 1'b0;
      end
   end

   // timeout counter reloads outside WAIT_RSP so it is armed on entry
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_tmo_cnt    <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= 32'h0;
         bus_error    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         wb_valid     <= w_complete;
         wb_reg_write <= w_complete & w_wb_reg_write;
         bus_error    <= w_timeout;
         if (w_complete) begin
            wb_rd   <= rd_address_in;
            wb_data <= w_wb_data;
         end
         if (r_state != WAIT_RSP)
            r_tmo_cnt <= TMO_LOAD;
         else if (r_tmo_cnt != '0)
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end
   end

`ifdef MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) misalign_out <= 1'b0;
      else       misalign_out <= (r_state == IDLE) & w_misalign;
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: randomized loads/stores/non-memory ops against a
// lane/extension reference model, plus timeout, reset-abandon and misalign scenarios.
module tb_mem_access_unit;
   localparam int TMO = 4;
`ifdef MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] alu_result_in, write_data_in, pc_plus_four_in, dmem_rdata;
   logic [4:0]  rd_address_in;
   logic        data_write_en_in, reg_write_in, dmem_req_ready, dmem_rsp_valid;
   logic [1:0]  alu_or_load_or_pc_plus_four_in, data_mem_write_command_in;
   logic [2:0]  load_gen_command_in;
   logic        dmem_req_valid, dmem_we, stall_out, wb_valid, wb_reg_write, bus_error;
   logic [31:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  dmem_wstrb;
   logic [4:0]  wb_rd;
`ifdef MISALIGN_CHECK_EN
   logic        misalign_out;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.RSP_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .alu_result_in(alu_result_in), .write_data_in(write_data_in),
      .rd_address_in(rd_address_in), .data_write_en_in(data_write_en_in),
      .reg_write_in(reg_write_in),
      .alu_or_load_or_pc_plus_four_in(alu_or_load_or_pc_plus_four_in),
      .pc_plus_four_in(pc_plus_four_in),
      .data_mem_write_command_in(data_mem_write_command_in),
      .load_gen_command_in(load_gen_command_in),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .stall_out(stall_out), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef MISALIGN_CHECK_EN
      .misalign_out(misalign_out),
`endif
      .bus_error(bus_error)
   );

   // reference model: access size 0=byte 1=half 2=word
   function automatic int st_size(logic [1:0] cmd);
      return (cmd >= 2'd2) ? 2 : int'(cmd);
   endfunction

   function automatic int ld_size(logic [2:0] lg);
      if (lg == 3'd0 || lg == 3'd4) return 0;
      if (lg == 3'd1 || lg == 3'd5) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] legal_addr(logic [31:0] a, int sz);
      if (MIS_EN && sz == 1) return a & ~32'd1;
      if (MIS_EN && sz == 2) return a & ~32'd3;
      return a;
   endfunction

   function automatic logic [3:0] exp_strb(int sz, logic [31:0] a);
      if (sz == 0) return 4'(1 << (a % 4));
      if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(int sz, logic [31:0] d);
      if (sz == 0) return (d & 32'hFF) * 32'h01010101;
      if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(logic [2:0] lg, logic [31:0] a, logic [31:0] rd);
      int sz;
      logic [31:0] v;
      sz = ld_size(lg);
      if (sz == 2) return rd;
      if (sz == 0) begin
         v = (rd >> (8 * (a % 4))) & 32'hFF;
         if (lg < 3'd4 && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else begin
         v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (lg < 3'd4 && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      data_write_en_in = 1'b0; alu_or_load_or_pc_plus_four_in = 2'b01; load_gen_command_in = 3'b010;
      alu_result_in = 32'h40; rd_address_in = 5'd7; reg_write_in = 1'b1;
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h12345678;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({dmem_req_valid, stall_out, wb_valid, wb_reg_write, bus_error} !== 5'b0) begin
         errors++;
         $display("FAIL rst_ctrl got %b required 00000", {dmem_req_valid, stall_out, wb_valid, wb_reg_write, bus_error});
      end
      checks++;
      if ({wb_rd, wb_data} !== 37'h0) begin
         errors++; $display("FAIL rst_wb got rd=%0d data=%h required 0/0", wb_rd, wb_data);
      end
      @(negedge clk);
      reset = 1'b0; alu_or_load_or_pc_plus_four_in = 2'b00;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
   endtask

   task automatic test_nonmem();
      logic [1:0] sel;
      logic [31:0] alu, pc, exp;
      logic [4:0] rd;
      logic rw;
      for (int n = 0; n < 10; n++) begin
         alu = $urandom; pc = $urandom; rd = 5'($urandom); rw = 1'($urandom);
         sel = (n % 3 == 0) ? 2'b00 : (n % 3 == 1) ? 2'b10 : 2'b11;
         if (n == 0) begin sel = 2'b10; pc = 32'h104; rd = 5'd1; rw = 1'b1; end
         exp = (sel == 2'b10) ? pc : alu;
         @(negedge clk);
         data_write_en_in = 1'b0; alu_or_load_or_pc_plus_four_in = sel; alu_result_in = alu;
         pc_plus_four_in = pc; rd_address_in = rd; reg_write_in = rw; write_data_in = $urandom;
         data_mem_write_command_in = 2'($urandom); load_gen_command_in = 3'($urandom);
         dmem_req_ready = 1'($urandom); dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
         #1;
         checks++;
         if ({dmem_req_valid, stall_out} !== 2'b00) begin
            errors++; $display("FAIL nm_req_stall got %b required 00", {dmem_req_valid, stall_out});
         end
         @(posedge clk); #1;
         checks++;
         if ({wb_valid, wb_reg_write, wb_rd} !== {1'b1, rw, rd}) begin
            errors++; $display("FAIL nm_wb got v=%b rw=%b rd=%0d required 1/%b/%0d", wb_valid, wb_reg_write, wb_rd, rw, rd);
         end
         checks++;
         if (wb_data !== exp) begin
            errors++; $display("FAIL nm_data got %h required %h", wb_data, exp);
         end
      end
   endtask

   task automatic test_store();
      logic [31:0] addr, data;
      logic [1:0] cmd;
      logic [4:0] rd;
      int sz, dly;
      for (int n = 0; n < 12; n++) begin
         cmd = 2'($urandom); data = $urandom; dly = $urandom_range(0, 3); rd = 5'($urandom);
         addr = legal_addr($urandom, st_size(cmd));
         if (n == 0) begin cmd = 2'b00; addr = 32'h1003; data = 32'hAB; dly = 0; end
         sz = st_size(cmd);
         for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            data_write_en_in = 1'b1; alu_or_load_or_pc_plus_four_in = 2'b00; alu_result_in = addr;
            write_data_in = data; data_mem_write_command_in = cmd; rd_address_in = rd; reg_write_in = 1'b1;
            dmem_req_ready = (i == dly); dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
            #1;
            checks++;
            if ({dmem_req_valid, dmem_we, stall_out} !== {2'b11, i != dly}) begin
               errors++; $display("FAIL st_ctrl got %b required %b", {dmem_req_valid, dmem_we, stall_out}, {2'b11, i != dly});
            end
            checks++;
            if ({dmem_addr, dmem_wstrb, dmem_wdata} !== {addr & ~32'd3, exp_strb(sz, addr), exp_wdata(sz, data)}) begin
               errors++;
               $display("FAIL st_bus got a=%h s=%b d=%h required a=%h s=%b d=%h", dmem_addr, dmem_wstrb, dmem_wdata,
                        addr & ~32'd3, exp_strb(sz, addr), exp_wdata(sz, data));
            end
            @(posedge clk); #1;
            checks++;
            if ({wb_valid, wb_reg_write} !== {i == dly, 1'b0}) begin
               errors++; $display("FAIL st_wb got v=%b rw=%b required %b/0", wb_valid, wb_reg_write, i == dly);
            end
         end
      end
   endtask

   task automatic test_load();
      logic [2:0] codes [8];
      logic [31:0] addr, rdat, exp;
      logic [2:0] lg;
      logic [4:0] rd;
      logic rw;
      int dly, rdly;
      codes = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
      for (int n = 0; n < 14; n++) begin
         lg = codes[$urandom_range(0, 7)]; rdat = $urandom; rd = 5'($urandom); rw = 1'($urandom);
         dly = $urandom_range(0, 3); rdly = $urandom_range(0, 2);
         addr = legal_addr($urandom, ld_size(lg));
         if (n < 2) begin
            lg = (n == 0) ? 3'd0 : 3'd4; addr = 32'h2001; rdat = 32'h00008000; dly = 3; rdly = 0;
         end
         exp = exp_load(lg, addr, rdat);
         for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            data_write_en_in = 1'b0; alu_or_load_or_pc_plus_four_in = 2'b01; alu_result_in = addr;
            load_gen_command_in = lg; rd_address_in = rd; reg_write_in = rw;
            dmem_req_ready = (i == dly); dmem_rsp_valid = 1'($urandom); dmem_rdata = $urandom;
            #1;
            checks++;
            if ({dmem_req_valid, dmem_we, stall_out, dmem_addr} !== {3'b101, addr & ~32'd3}) begin
               errors++; $display("FAIL ld_req got v=%b we=%b st=%b a=%h required 1/0/1/%h",
                                  dmem_req_valid, dmem_we, stall_out, dmem_addr, addr & ~32'd3);
            end
            @(posedge clk); #1;
            checks++;
            if (wb_valid !== 1'b0) begin
               errors++; $display("FAIL ld_req_wb got %b required 0", wb_valid);
            end
         end
         for (int j = 0; j <= rdly; j++) begin
            @(negedge clk);
            dmem_req_ready = 1'($urandom); dmem_rsp_valid = (j == rdly);
            dmem_rdata = (j == rdly) ? rdat : $urandom;
            #1;
            checks++;
            if ({dmem_req_valid, stall_out} !== {1'b0, j != rdly}) begin
               errors++; $display("FAIL ld_wait got %b required %b", {dmem_req_valid, stall_out}, {1'b0, j != rdly});
            end
            @(posedge clk); #1;
            checks++;
            if (wb_valid !== (j == rdly)) begin
               errors++; $display("FAIL ld_wb_valid got %b required %b", wb_valid, j == rdly);
            end
         end
         checks++;
         if ({wb_data, wb_rd, wb_reg_write} !== {exp, rd, rw}) begin
            errors++; $display("FAIL ld_data lg=%0d a=%h got %h/%0d/%b required %h/%0d/%b",
                               lg, addr, wb_data, wb_rd, wb_reg_write, exp, rd, rw);
         end
      end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      data_write_en_in = 1'b0; alu_or_load_or_pc_plus_four_in = 2'b01; alu_result_in = 32'h500;
      load_gen_command_in = 3'b010; rd_address_in = 5'd9; reg_write_in = 1'b1;
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      for (int w = 1; w <= TMO; w++) begin
         @(negedge clk);
         dmem_req_ready = 1'($urandom); dmem_rsp_valid = 1'b0;
         #1;
         checks++;
         if ({dmem_req_valid, stall_out} !== {1'b0, w < TMO}) begin
            errors++; $display("FAIL tmo_stall w=%0d got %b required %b", w, {dmem_req_valid, stall_out}, {1'b0, w < TMO});
         end
         @(posedge clk); #1;
         checks++;
         if ({wb_valid, bus_error} !== {2{w == TMO}}) begin
            errors++; $display("FAIL tmo_pulse w=%0d got %b required %b", w, {wb_valid, bus_error}, {2{w == TMO}});
         end
      end
      checks++;
      if (wb_data !== 32'h0) begin
         errors++; $display("FAIL tmo_data got %h required 00000000", wb_data);
      end
      @(negedge clk);
      alu_or_load_or_pc_plus_four_in = 2'b00; alu_result_in = 32'h77; dmem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus_error, wb_valid, wb_data} !== {2'b01, 32'h77}) begin
         errors++; $display("FAIL tmo_after got be=%b v=%b d=%h required 0/1/00000077", bus_error, wb_valid, wb_data);
      end
   endtask

   task automatic test_reset_inflight();
      @(negedge clk);
      data_write_en_in = 1'b0; alu_or_load_or_pc_plus_four_in = 2'b01; alu_result_in = 32'h600;
      load_gen_command_in = 3'b010; reg_write_in = 1'b1; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      dmem_req_ready = 1'b0;
      #1;
      checks++;
      if ({dmem_req_valid, stall_out} !== 2'b01) begin
         errors++; $display("FAIL ri_wait got %b required 01", {dmem_req_valid, stall_out});
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, stall_out, dmem_req_valid} !== 3'b000) begin
         errors++; $display("FAIL ri_reset got %b required 000", {wb_valid, stall_out, dmem_req_valid});
      end
      @(negedge clk);
      reset = 1'b0; data_write_en_in = 1'b1; alu_or_load_or_pc_plus_four_in = 2'b00;
      alu_result_in = 32'h700; data_mem_write_command_in = 2'b10; write_data_in = $urandom;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD0000;
      #1;
      checks++;
      if ({dmem_req_valid, dmem_we, stall_out} !== 3'b111) begin
         errors++; $display("FAIL ri_idle got %b required 111", {dmem_req_valid, dmem_we, stall_out});
      end
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++; $display("FAIL ri_late_rsp got wb_valid=%b required 0", wb_valid);
      end
      @(negedge clk);
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_reg_write} !== 2'b10) begin
         errors++; $display("FAIL ri_store got %b required 10", {wb_valid, wb_reg_write});
      end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      data_write_en_in = 1'b1; alu_or_load_or_pc_plus_four_in = 2'b00; alu_result_in = 32'h3002;
      data_mem_write_command_in = 2'b10; write_data_in = 32'h11223344; reg_write_in = 1'b1;
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
      #1;
`ifdef MISALIGN_CHECK_EN
      checks++;
      if ({dmem_req_valid, stall_out} !== 2'b00) begin
         errors++; $display("FAIL ma_req got %b required 00", {dmem_req_valid, stall_out});
      end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_reg_write, misalign_out} !== 3'b101) begin
         errors++; $display("FAIL ma_sw got %b required 101", {wb_valid, wb_reg_write, misalign_out});
      end
      @(negedge clk);
      data_write_en_in = 1'b0; alu_or_load_or_pc_plus_four_in = 2'b01; alu_result_in = 32'h11;
      load_gen_command_in = 3'b001;
      #1;
      checks++;
      if (dmem_req_valid !== 1'b0) begin
         errors++; $display("FAIL ma_lh_req got %b required 0", dmem_req_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_reg_write, misalign_out} !== 3'b101) begin
         errors++; $display("FAIL ma_lh got %b required 101", {wb_valid, wb_reg_write, misalign_out});
      end
      @(negedge clk);
      alu_or_load_or_pc_plus_four_in = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (misalign_out !== 1'b0) begin
         errors++; $display("FAIL ma_pulse got %b required 0", misalign_out);
      end
`else
      checks++;
      if ({dmem_req_valid, dmem_addr, dmem_wstrb, dmem_wdata} !== {1'b1, 32'h3000, 4'hF, 32'h11223344}) begin
         errors++; $display("FAIL ma_sw_pass got v=%b a=%h s=%b d=%h required 1/00003000/1111/11223344",
                            dmem_req_valid, dmem_addr, dmem_wstrb, dmem_wdata);
      end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_reg_write} !== 2'b10) begin
         errors++; $display("FAIL ma_sw_wb got %b required 10", {wb_valid, wb_reg_write});
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      alu_result_in = '0; write_data_in = '0; pc_plus_four_in = '0; dmem_rdata = '0;
      rd_address_in = '0; data_write_en_in = 1'b0; reg_write_in = 1'b0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      alu_or_load_or_pc_plus_four_in = 2'b00; data_mem_write_command_in = 2'b00;
      load_gen_command_in = 3'b000;
      test_reset();
      test_nonmem();
      test_store();
      test_load();
      test_timeout();
      test_reset_inflight();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: RSP_TIMEOUT, 255, maximum cycles spent in WAIT_RSP (0 = no timeout).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_result_in  in  32  effective address / ALU result from EX/MEM register
- write_data_in  in  32  store data (low bits significant)
- rd_address_in  in  5  destination register
- data_write_en_in  in  1  store request
- reg_write_in  in  1  register write enable
- alu_or_load_or_pc_plus_four_in  in  2  writeback select: 00 ALU, 01 load, 10 PC+4, 11 ALU
- pc_plus_four_in  in  32  link value
- data_mem_write_command_in  in  2  store size: 00 byte, 01 half, 10/11 word
- load_gen_command_in  in  3  load format: 000 LB, 001 LH, 100 LBU, 101 LHU, others LW
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  32  word-aligned address (alu_result_in with [1:0] = 00)
- dmem_we  out  1  1 = store, 0 = load
- dmem_wstrb  out  4  byte strobes
- dmem_wdata  out  32  lane-replicated store data
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  32  load data word
- stall_out  out  1  hold upstream pipeline
- wb_valid  out  1  writeback bundle valid
- wb_reg_write, wb_rd, wb_data  out  1/5/32  registered writeback
- bus_error  out  1  one-cycle pulse on response timeout

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT_RSP; memory op = data_write_en_in or select 01.
REQ-004 SHALL, for a non-memory op in IDLE, register wb bundle on next edge: wb_valid=1; wb_data=ALU or PC+4 per select; latency 1.
REQ-005 SHALL, for a memory op in IDLE, assert dmem_req_valid combinationally in that cycle and enter REQ if not accepted.
REQ-006 SHALL hold dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata stable until dmem_req_valid & dmem_req_ready.
REQ-007 SHALL, on store acceptance, return to IDLE and register wb_valid=1, wb_reg_write=0.
REQ-008 SHALL, on load acceptance, enter WAIT_RSP; dmem_rsp_valid is ignored in any other state.
REQ-009 SHALL, on dmem_rsp_valid in WAIT_RSP, select byte/half lane by address bits [1:0]/[1], sign- or zero-extend per load_gen_command_in, register wb_data, wb_valid=1, and go IDLE.
REQ-010 SHALL generate store strobes: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; data replicated across lanes.
REQ-011 SHALL assert stall_out combinationally from start of memory op until (excluding) its completion cycle; completion = store acceptance or load response.
REQ-012 SHALL drive wb_valid=0 on every edge where no op completes (bubble).
REQ-013 SHALL, if RSP_TIMEOUT>0 and WAIT_RSP lasts RSP_TIMEOUT cycles, complete with wb_data=0, pulse bus_error, go IDLE.
REQ-014 SHALL require upstream inputs stable while stall_out=1.

Reset
REQ-015 SHALL, on reset, go IDLE and clear dmem_req_valid, stall_out, wb_valid, wb_reg_write, wb_rd, wb_data, bus_error, timeout counter to 0.
REQ-016 SHALL abandon any in-flight request on reset; a late response after reset SHALL be ignored.

Configuration
REQ-017 SHALL, with MISALIGN_CHECK_EN defined, treat half at addr[0]=1 or word at addr[1:0]!=00 as misaligned: no bus request, wb_valid=1 with wb_reg_write=0, output misalign_out pulses 1 cycle; without it, no misalign_out port and misaligned addresses use REQ-009/010 lane rules unchanged.

Verification
REQ-018 SB addr 0x1003, data 0x000000AB, ready=1 -> wstrb 1000, wdata 0xABABABAB, stall 0 cycles beyond issue, wb_reg_write=0.
REQ-019 LB addr 0x2001, rdata 0x0000_80_00 after 3-cycle ready delay -> stall high 3+ cycles, wb_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-020 JAL-type select 10, pc_plus_four 0x104, rd 1 -> next edge wb_valid=1, wb_rd=1, wb_data 0x104, no dmem_req_valid.
REQ-021 LW with no response, RSP_TIMEOUT=4 -> bus_error pulse after 4 WAIT_RSP cycles, wb_data 0, stall released.
REQ-022 reset asserted in WAIT_RSP, then rsp_valid -> IDLE, wb_valid stays 0, response ignored.
REQ-023 MISALIGN_CHECK_EN, SW addr 0x3002 -> no dmem_req_valid, misalign_out pulse, wb_reg_write=0.
